idex_regs: RTL and testbench

//  ID/EX pipeline register. Captures decoded fields from idu and forwarded rs1/rs2 operands from the bypass network each cycle.

---
 rtl/idex_regs.sv | 172 +++++++++++++++++
 tb/tb_idex_regs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_regs.sv
// rtl/idex_regs.sv - ID/EX pipeline register with bubble insertion, stall hold and bubble counter
//
// Captures decoded fields and forwarded operands from the decode stage and
// presents them to the execute stage one cycle later.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_idu_valid .. i_idu_lsopt   decoded instruction fields and forwarded operands
//   i_idex_nop                   load-use bubble request
//   i_flush                      redirect, kill the decode-stage instruction
//   i_stall                      downstream busy, hold the register
//   o_exu_valid .. o_exu_lsopt   registered copies of the i_idu_* fields
//   o_bubble_cnt                 saturating count of bubbles inserted since reset
module idex_regs #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int EXOPT_W   = 6,
  parameter int LSOPT_W   = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_idu_valid,
  input  logic [CPU_WIDTH-1:0] i_idu_pc,
  input  logic [31:0]          i_idu_inst,
  input  logic [CPU_WIDTH-1:0] i_idu_rs1,
  input  logic [CPU_WIDTH-1:0] i_idu_rs2,
  input  logic [CPU_WIDTH-1:0] i_idu_imm,
  input  logic [REG_ADDRW-1:0] i_idu_rdid,
  input  logic                 i_idu_rdwen,
  input  logic                 i_idu_lden,
  input  logic                 i_idu_sten,
  input  logic [EXOPT_W-1:0]   i_idu_exopt,
  input  logic [LSOPT_W-1:0]   i_idu_lsopt,
  input  logic                 i_idex_nop,
  input  logic                 i_flush,
  input  logic                 i_stall,
  output logic                 o_exu_valid,
  output logic [CPU_WIDTH-1:0] o_exu_pc,
  output logic [31:0]          o_exu_inst,
  output logic [CPU_WIDTH-1:0] o_exu_rs1,
  output logic [CPU_WIDTH-1:0] o_exu_rs2,
  output logic [CPU_WIDTH-1:0] o_exu_imm,
  output logic [REG_ADDRW-1:0] o_exu_rdid,
  output logic                 o_exu_rdwen,
  output logic                 o_exu_lden,
  output logic                 o_exu_sten,
  output logic [EXOPT_W-1:0]   o_exu_exopt,
  output logic [LSOPT_W-1:0]   o_exu_lsopt,
  output logic [CNT_W-1:0]     o_bubble_cnt
);

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic                 valid_q, valid_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]          inst_q, inst_d;
  logic [CPU_WIDTH-1:0] rs1_q, rs1_d;
  logic [CPU_WIDTH-1:0] rs2_q, rs2_d;
  logic [CPU_WIDTH-1:0] imm_q, imm_d;
  logic [REG_ADDRW-1:0] rdid_q, rdid_d;
  logic                 rdwen_q, rdwen_d;
  logic                 lden_q, lden_d;
  logic                 sten_q, sten_d;
  logic [EXOPT_W-1:0]   exopt_q, exopt_d;
  logic [LSOPT_W-1:0]   lsopt_q, lsopt_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

  logic load_bubble;
  logic hold;

  // Flush outranks stall: a redirect must kill the instruction even while
  // the execute stage is busy. Stall outranks the load-use bubble.
  assign load_bubble = i_flush | (~i_stall & i_idex_nop);
  assign hold        = ~i_flush & i_stall;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    rdid_d       = rdid_q;
    rdwen_d      = rdwen_q;
    lden_d       = lden_q;
    sten_d       = sten_q;
    exopt_d      = exopt_q;
    lsopt_d      = lsopt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (load_bubble) begin
      valid_d = 1'b0;
      pc_d    = '0;
      inst_d  = NOP_INST;
      rs1_d   = '0;
      rs2_d   = '0;
      imm_d   = '0;
      rdid_d  = '0;
      rdwen_d = 1'b0;
      lden_d  = 1'b0;
      sten_d  = 1'b0;
      exopt_d = '0;
      lsopt_d = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!hold) begin
      valid_d = i_idu_valid;
      pc_d    = i_idu_pc;
      inst_d  = i_idu_inst;
      rs1_d   = i_idu_rs1;
      rs2_d   = i_idu_rs2;
      imm_d   = i_idu_imm;
      rdid_d  = i_idu_rdid;
      // An invalid slot must never write a register or touch memory.
      rdwen_d = i_idu_valid & i_idu_rdwen;
      lden_d  = i_idu_valid & i_idu_lden;
      sten_d  = i_idu_valid & i_idu_sten;
      exopt_d = i_idu_exopt;
      lsopt_d = i_idu_lsopt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      inst_q       <= NOP_INST;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      rdid_q       <= '0;
      rdwen_q      <= 1'b0;
      lden_q       <= 1'b0;
      sten_q       <= 1'b0;
      exopt_q      <= '0;
      lsopt_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      rdid_q       <= rdid_d;
      rdwen_q      <= rdwen_d;
      lden_q       <= lden_d;
      sten_q       <= sten_d;
      exopt_q      <= exopt_d;
      lsopt_q      <= lsopt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_exu_valid  = valid_q;
  assign o_exu_pc     = pc_q;
  assign o_exu_inst   = inst_q;
  assign o_exu_rs1    = rs1_q;
  assign o_exu_rs2    = rs2_q;
  assign o_exu_imm    = imm_q;
  assign o_exu_rdid   = rdid_q;
  assign o_exu_rdwen  = rdwen_q;
  assign o_exu_lden   = lden_q;
  assign o_exu_sten   = sten_q;
  assign o_exu_exopt  = exopt_q;
  assign o_exu_lsopt  = lsopt_q;
  assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_idex_regs.sv
// tb/tb_idex_regs.sv - directed self-checking bench for idex_regs
module tb_idex_regs;

  logic        clk;
  logic        rst_n;
  logic        idu_valid;
  logic [63:0] idu_pc;
  logic [31:0] idu_inst;
  logic [63:0] idu_rs1;
  logic [63:0] idu_rs2;
  logic [63:0] idu_imm;
  logic [4:0]  idu_rdid;
  logic        idu_rdwen;
  logic        idu_lden;
  logic        idu_sten;
  logic [5:0]  idu_exopt;
  logic [3:0]  idu_lsopt;
  logic        idex_nop;
  logic        flush;
  logic        stall;

  logic        exu_valid;
  logic [63:0] exu_pc;
  logic [31:0] exu_inst;
  logic [63:0] exu_rs1;
  logic [63:0] exu_rs2;
  logic [63:0] exu_imm;
  logic [4:0]  exu_rdid;
  logic        exu_rdwen;
  logic        exu_lden;
  logic        exu_sten;
  logic [5:0]  exu_exopt;
  logic [3:0]  exu_lsopt;
  logic [31:0] bubble_cnt;

  logic        d4_valid;
  logic [63:0] d4_pc;
  logic [31:0] d4_inst;
  logic [63:0] d4_rs1;
  logic [63:0] d4_rs2;
  logic [63:0] d4_imm;
  logic [4:0]  d4_rdid;
  logic        d4_rdwen;
  logic        d4_lden;
  logic        d4_sten;
  logic [5:0]  d4_exopt;
  logic [3:0]  d4_lsopt;
  logic [3:0]  d4_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  idex_regs dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_idu_valid(idu_valid), .i_idu_pc(idu_pc), .i_idu_inst(idu_inst),
    .i_idu_rs1(idu_rs1), .i_idu_rs2(idu_rs2), .i_idu_imm(idu_imm),
    .i_idu_rdid(idu_rdid), .i_idu_rdwen(idu_rdwen), .i_idu_lden(idu_lden),
    .i_idu_sten(idu_sten), .i_idu_exopt(idu_exopt), .i_idu_lsopt(idu_lsopt),
    .i_idex_nop(idex_nop), .i_flush(flush), .i_stall(stall),
    .o_exu_valid(exu_valid), .o_exu_pc(exu_pc), .o_exu_inst(exu_inst),
    .o_exu_rs1(exu_rs1), .o_exu_rs2(exu_rs2), .o_exu_imm(exu_imm),
    .o_exu_rdid(exu_rdid), .o_exu_rdwen(exu_rdwen), .o_exu_lden(exu_lden),
    .o_exu_sten(exu_sten), .o_exu_exopt(exu_exopt), .o_exu_lsopt(exu_lsopt),
    .o_bubble_cnt(bubble_cnt)
  );

  idex_regs #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_idu_valid(idu_valid), .i_idu_pc(idu_pc), .i_idu_inst(idu_inst),
    .i_idu_rs1(idu_rs1), .i_idu_rs2(idu_rs2), .i_idu_imm(idu_imm),
    .i_idu_rdid(idu_rdid), .i_idu_rdwen(idu_rdwen), .i_idu_lden(idu_lden),
    .i_idu_sten(idu_sten), .i_idu_exopt(idu_exopt), .i_idu_lsopt(idu_lsopt),
    .i_idex_nop(idex_nop), .i_flush(flush), .i_stall(stall),
    .o_exu_valid(d4_valid), .o_exu_pc(d4_pc), .o_exu_inst(d4_inst),
    .o_exu_rs1(d4_rs1), .o_exu_rs2(d4_rs2), .o_exu_imm(d4_imm),
    .o_exu_rdid(d4_rdid), .o_exu_rdwen(d4_rdwen), .o_exu_lden(d4_lden),
    .o_exu_sten(d4_sten), .o_exu_exopt(d4_exopt), .o_exu_lsopt(d4_lsopt),
    .o_bubble_cnt(d4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic rdwen);
    idu_valid = v;
    idu_pc    = pc;
    idu_inst  = pc[31:0] ^ 32'h00A0_0093;
    idu_rs1   = pc + 64'h100;
    idu_rs2   = pc + 64'h200;
    idu_imm   = {32'hFFFF_FFFF, pc[31:0]};
    idu_rdid  = pc[6:2];
    idu_rdwen = rdwen;
    idu_lden  = 1'b0;
    idu_sten  = 1'b0;
    idu_exopt = pc[7:2];
    idu_lsopt = pc[5:2];
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(exu_valid), 64'd0);
    chk({tag, ".pc"},    exu_pc, 64'd0);
    chk({tag, ".inst"},  64'(exu_inst), 64'h13);
    chk({tag, ".rdwen"}, 64'(exu_rdwen), 64'd0);
    chk({tag, ".rs1"},   exu_rs1, 64'd0);
    chk({tag, ".exopt"}, 64'(exu_exopt), 64'd0);
  endtask

  initial begin
    logic [63:0] pc;
    rst_n = 1'b0;
    idex_nop = 1'b0; flush = 1'b0; stall = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // 1 reset: load valid data, then assert reset mid-cycle
    drive(1'b1, 64'h1234, 1'b1);
    idu_lden = 1'b1;
    tick();
    chk("pre_reset.pc", exu_pc, 64'h1234);
    chk("pre_reset.lden", 64'(exu_lden), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset.valid", 64'(exu_valid), 64'd0);
    chk("reset.pc", exu_pc, 64'd0);
    chk("reset.inst", 64'(exu_inst), 64'h13);
    chk("reset.rdwen", 64'(exu_rdwen), 64'd0);
    chk("reset.lden", 64'(exu_lden), 64'd0);
    chk("reset.cnt", 64'(bubble_cnt), 64'd0);
    #3;
    rst_n = 1'b1;

    // 2 flow
    for (int i = 0; i < 4; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      drive(1'b1, pc, 1'b1);
      tick();
      chk("flow.pc", exu_pc, pc);
      chk("flow.valid", 64'(exu_valid), 64'd1);
      chk("flow.inst", 64'(exu_inst), 64'(pc[31:0] ^ 32'h00A0_0093));
      chk("flow.rs2", exu_rs2, pc + 64'h200);
      chk("flow.imm", exu_imm, {32'hFFFF_FFFF, pc[31:0]});
    end

    // 3 load-use
    drive(1'b1, 64'h8000_0010, 1'b1);
    idex_nop = 1'b1;
    tick();
    exp_cnt++;
    chk_bubble("loaduse");
    chk("loaduse.cnt", 64'(bubble_cnt), 64'(exp_cnt));
    idex_nop = 1'b0;
    tick();
    chk("loaduse.reload.pc", exu_pc, 64'h8000_0010);
    chk("loaduse.reload.rdwen", 64'(exu_rdwen), 64'd1);
    chk("loaduse.reload.cnt", 64'(bubble_cnt), 64'(exp_cnt));

    // 4 stall: nop during stall is also ignored
    drive(1'b1, 64'h8000_0020, 1'b1);
    tick();
    chk("stall.load.pc", exu_pc, 64'h8000_0020);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h9000_0000 + 64'(i * 4), 1'b0);
      idex_nop = (i == 1);
      tick();
      chk("stall.pc", exu_pc, 64'h8000_0020);
      chk("stall.rdwen", 64'(exu_rdwen), 64'd1);
      chk("stall.rs1", exu_rs1, 64'h8000_0120);
      chk("stall.cnt", 64'(bubble_cnt), 64'(exp_cnt));
    end

    // 5 flush priority
    idex_nop = 1'b1;
    flush = 1'b1;
    tick();
    exp_cnt++;
    chk_bubble("flush");
    chk("flush.cnt", 64'(bubble_cnt), 64'(exp_cnt));
    flush = 1'b0; stall = 1'b0; idex_nop = 1'b0;
    drive(1'b0, 64'h8000_0030, 1'b1);
    idu_lden = 1'b1;
    idu_sten = 1'b1;
    tick();
    chk("invalid.valid", 64'(exu_valid), 64'd0);
    chk("invalid.pc", exu_pc, 64'h8000_0030);
    chk("invalid.rdwen", 64'(exu_rdwen), 64'd0);
    chk("invalid.lden", 64'(exu_lden), 64'd0);
    chk("invalid.sten", 64'(exu_sten), 64'd0);

    // 6 saturation on the 4-bit counter build
    chk("sat.start", 64'(d4_cnt), 64'(exp_cnt));
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt++;
      chk("sat.cnt4", 64'(d4_cnt), 64'((exp_cnt > 15) ? 15 : exp_cnt));
    end
    chk("sat.cnt32", 64'(bubble_cnt), 64'(exp_cnt));
    flush = 1'b0;
    stall = 1'b1;
    tick();
    chk("sat.hold", 64'(d4_cnt), 64'hF);
    stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
